add_sat_pipe: RTL and testbench

Parametrised two-operand adder for the add datapath. It accepts the a/b operand pair that the add_in agent drives and returns results through a valid/ready output port. Compared with the plain adder it adds generic width, selectable wrap or saturating arithmetic (unsigned or signed), carry and overflow flags, and a FIFO_DEPTH-entry result FIFO with backpressure.

---
 rtl/add_sat_if.sv | 29 ++
 rtl/add_sat_pipe.sv | 115 +++++++++++
 tb/tb_add_sat_pipe.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/add_sat_if.sv
// Operand/result bundle for add_sat_pipe: operand handshake in, result FIFO head out.
interface add_sat_if #(
  parameter int ADD_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic                 in_valid;
  logic                 in_ready;
  logic [ADD_WIDTH-1:0] a;
  logic [ADD_WIDTH-1:0] b;
  logic [1:0]           mode;
  logic                 out_valid;
  logic                 out_ready;
  logic [ADD_WIDTH-1:0] sum;
  logic                 carry;
  logic                 ovf;
  logic [CW-1:0]        fifo_count;

  modport master (
    output in_valid, a, b, mode, out_ready,
    input  in_ready, out_valid, sum, carry, ovf, fifo_count
  );

  modport slave (
    input  in_valid, a, b, mode, out_ready,
    output in_ready, out_valid, sum, carry, ovf, fifo_count
  );
endinterface

// File: rtl/add_sat_pipe.sv
// Two-operand adder with wrap / unsigned-sat / signed-sat modes, one compute
// stage and a small result FIFO with valid/ready backpressure.
module add_sat_pipe #(
  parameter int ADD_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic     clk,
  input  logic     rst,
  add_sat_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  typedef struct packed {
    logic [ADD_WIDTH-1:0] sum;
    logic                 carry;
    logic                 ovf;
  } res_t;

  // compute stage S
  logic                 s_valid;
  logic [ADD_WIDTH-1:0] s_a, s_b;
  logic [1:0]           s_mode;
  logic [ADD_WIDTH:0]   full;
  res_t                 s_res;

  // result FIFO
  res_t          mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          out_valid_q;

  logic          accept, push, pop;
  logic [CW:0]   occ;

  // Credit counts the entry sitting in S; a same-cycle pop is deliberately ignored.
  assign occ          = {1'b0, count} + {{CW{1'b0}}, s_valid};
  assign bus.in_ready = rst && (occ < DEPTH_C);
  assign accept       = bus.in_valid && bus.in_ready;
  assign push         = s_valid;
  assign pop          = out_valid_q && bus.out_ready;

  // Capture operands into S on accept; S drains into the FIFO every cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      s_valid <= 1'b0;
      s_a     <= '0;
      s_b     <= '0;
      s_mode  <= 2'b00;
    end else begin
      s_valid <= accept;
      if (accept) begin
        s_a    <= bus.a;
        s_b    <= bus.b;
        s_mode <= bus.mode;
      end
    end
  end

  // Add and clamp according to mode; carry is the raw unsigned carry in every mode.
  always_comb begin
    full        = {1'b0, s_a} + {1'b0, s_b};
    s_res.sum   = full[ADD_WIDTH-1:0];
    s_res.carry = full[ADD_WIDTH];
    s_res.ovf   = 1'b0;
    case (s_mode)
      2'b01: begin
        if (full[ADD_WIDTH]) begin
          s_res.sum = '1;
          s_res.ovf = 1'b1;
        end
      end
      2'b10: begin
        if ((s_a[ADD_WIDTH-1] == s_b[ADD_WIDTH-1]) &&
            (full[ADD_WIDTH-1] != s_a[ADD_WIDTH-1])) begin
          s_res.ovf = 1'b1;
          s_res.sum = s_a[ADD_WIDTH-1] ? {1'b1, {(ADD_WIDTH-1){1'b0}}}
                                       : {1'b0, {(ADD_WIDTH-1){1'b1}}};
        end
      end
      default: ;
    endcase
  end

  // Occupancy after this cycle's push/pop; a simultaneous push and pop cancel.
  always_comb begin
    count_nxt = count + CW'(push) - CW'(pop);
  end

  // FIFO storage and pointers; out_valid is registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= s_res;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      out_valid_q <= (count_nxt != '0);
    end
  end

  assign bus.out_valid  = out_valid_q;
  assign bus.sum        = mem[rd_ptr].sum;
  assign bus.carry      = mem[rd_ptr].carry;
  assign bus.ovf        = mem[rd_ptr].ovf;
  assign bus.fifo_count = count;
endmodule

// File: tb/tb_add_sat_pipe.sv
// Directed bench for add_sat_pipe (ADD_WIDTH=4, FIFO_DEPTH=4).
module tb_add_sat_pipe;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  add_sat_if #(.ADD_WIDTH(4), .FIFO_DEPTH(4)) bus ();

  add_sat_pipe #(.ADD_WIDTH(4), .FIFO_DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] mode;
    logic [3:0] sum;
    logic       carry;
    logic       ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int next_a, accepts, got, sent, first, last, maxc;
    bit acc;

    vecs[0] = '{4'd9,  4'd8,  2'b00, 4'd1,  1'b1, 1'b0};
    vecs[1] = '{4'd12, 4'd7,  2'b01, 4'd15, 1'b1, 1'b1};
    vecs[2] = '{4'd7,  4'd3,  2'b10, 4'd7,  1'b0, 1'b1};
    vecs[3] = '{4'd8,  4'd15, 2'b10, 4'd8,  1'b1, 1'b1};
    vecs[4] = '{4'd5,  4'd14, 2'b10, 4'd3,  1'b1, 1'b0};
    vecs[5] = '{4'd9,  4'd8,  2'b11, 4'd1,  1'b1, 1'b0};

    // reset held with in_valid asserted
    rst = 1'b0;
    bus.in_valid = 1'b1; bus.a = 4'd3; bus.b = 4'd3; bus.mode = 2'b00;
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_out_valid", int'(bus.out_valid), 0);
      chk("rst_in_ready", int'(bus.in_ready), 0);
      chk("rst_sum", int'(bus.sum), 0);
      chk("rst_count", int'(bus.fifo_count), 0);
    end
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    chk("rel_in_ready", int'(bus.in_ready), 1);
    tick(); tick();
    chk("rel_no_accept_valid", int'(bus.out_valid), 0);
    chk("rel_no_accept_count", int'(bus.fifo_count), 0);

    // single-operation vectors with latency check
    bus.out_ready = 1'b1;
    foreach (vecs[k]) begin
      bus.a = vecs[k].a; bus.b = vecs[k].b; bus.mode = vecs[k].mode;
      bus.in_valid = 1'b1;
      chk($sformatf("v%0d_in_ready", k), int'(bus.in_ready), 1);
      tick();
      bus.in_valid = 1'b0;
      chk($sformatf("v%0d_valid_e1", k), int'(bus.out_valid), 0);
      tick();
      chk($sformatf("v%0d_valid_e2", k), int'(bus.out_valid), 1);
      chk($sformatf("v%0d_sum", k), int'(bus.sum), int'(vecs[k].sum));
      chk($sformatf("v%0d_carry", k), int'(bus.carry), int'(vecs[k].carry));
      chk($sformatf("v%0d_ovf", k), int'(bus.ovf), int'(vecs[k].ovf));
      tick();
      chk($sformatf("v%0d_popped", k), int'(bus.out_valid), 0);
    end

    // backpressure: fill with out_ready low
    bus.out_ready = 1'b0; bus.b = 4'd0; bus.mode = 2'b00;
    next_a = 1; accepts = 0;
    for (int c = 0; c < 8; c++) begin
      bus.in_valid = 1'b1; bus.a = 4'(next_a);
      acc = bus.in_ready;
      if (bus.out_valid) chk("bp_hold_sum", int'(bus.sum), 1);
      tick();
      if (acc) begin accepts++; next_a++; end
    end
    chk("bp_accepts", accepts, 4);
    chk("bp_in_ready", int'(bus.in_ready), 0);
    chk("bp_count", int'(bus.fifo_count), 4);
    chk("bp_sum", int'(bus.sum), 1);

    // release: in_ready rises only after the first pop
    bus.out_ready = 1'b1;
    chk("bp_ready_before_pop", int'(bus.in_ready), 0);
    got = 0;
    for (int c = 0; c < 30 && got < 6; c++) begin
      bus.in_valid = (next_a <= 6); bus.a = 4'(next_a);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        got++;
        chk("bp_order", int'(bus.sum), got);
      end
      tick();
      if (c == 0) chk("bp_ready_after_pop", int'(bus.in_ready), 1);
      if (acc) next_a++;
    end
    bus.in_valid = 1'b0;
    chk("bp_got", got, 6);
    tick(); tick();
    chk("bp_drained", int'(bus.out_valid), 0);

    // streaming: 20 back-to-back operations
    sent = 0; got = 0; first = -1; last = -1; maxc = 0;
    bus.b = 4'd3; bus.mode = 2'b00; bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && got < 20; c++) begin
      bus.in_valid = (sent < 20); bus.a = 4'(sent);
      acc = bus.in_valid && bus.in_ready;
      if (bus.out_valid) begin
        chk("st_sum", int'(bus.sum), (got + 3) & 15);
        if (first < 0) first = c;
        last = c;
        got++;
      end
      if (int'(bus.fifo_count) > maxc) maxc = int'(bus.fifo_count);
      tick();
      if (acc) sent++;
    end
    bus.in_valid = 1'b0;
    chk("st_got", got, 20);
    chk("st_first", first, 2);
    chk("st_span", last - first, 19);
    chk("st_maxcount", maxc, 1);
    tick(); tick();

    // mid-operation reset: 3 in FIFO, 1 in S
    bus.out_ready = 1'b0; bus.b = 4'd0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1; bus.a = 4'(10 + i);
      tick();
    end
    bus.in_valid = 1'b0;
    chk("mr_pre_count", int'(bus.fifo_count), 3);
    rst = 1'b0;
    tick();
    chk("mr_valid", int'(bus.out_valid), 0);
    chk("mr_count", int'(bus.fifo_count), 0);
    rst = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mr_no_stale", int'(bus.out_valid), 0);
    end
    bus.a = 4'd2; bus.b = 4'd2; bus.mode = 2'b00; bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    got = 0;
    for (int c = 0; c < 10 && got == 0; c++) begin
      if (bus.out_valid) begin
        chk("mr_first_sum", int'(bus.sum), 4);
        got = 1;
      end
      tick();
    end
    chk("mr_result_seen", got, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
